mem_arbiter_rr: RTL and testbench

- Parametrised N-client arbiter for the shared Wishbone-side memory port; successor to the fixed four-slot VGA/UART/CPU request handler.
- Grants one client at a time: round-robin by default, with an optional sticky-priority client (e.g. VGA during active scan).
- Drives a single read/write strobe, tracks mem_busy to completion, and returns captured read data with a per-client ack.
- Includes a busy-timeout watchdog that completes a hung transfer with an error flag.

---
 rtl/mem_arbiter_rr.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-client arbiter for the shared memory port.
// Round-robin grant with an optional sticky-priority client, strobe/busy handshake and a busy-timeout abort.
module mem_arbiter_rr #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PRIO_CLIENT = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             prio_en,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS-1:0]           we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]    adr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]    wdata,
  input  logic [NUM_CLIENTS*DATA_W/8-1:0]  sel,
  output logic [NUM_CLIENTS-1:0]           ack,
  output logic [NUM_CLIENTS-1:0]           err,
  output logic [DATA_W-1:0]                rdata,
  output logic [$clog2(NUM_CLIENTS)-1:0]   grant_id,
  output logic                             busy,
  input  logic                             mem_busy,
  input  logic [DATA_W-1:0]                data_from_mem,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_W-1:0]                adr_to_mem,
  output logic [DATA_W-1:0]                data_to_mem,
  output logic [DATA_W/8-1:0]              sel_to_mem
);

  localparam int unsigned IDW = $clog2(NUM_CLIENTS);
  localparam int unsigned CW  = IDW + 1;
  localparam int unsigned SW  = DATA_W / 8;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [TW-1:0]   tcnt;
  logic            we_h;

  logic            found;
  logic [IDW-1:0]  pick;
  logic [CW-1:0]   cand;

  logic [ADDR_W-1:0] adr_a   [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_a [NUM_CLIENTS];
  logic [SW-1:0]     sel_a   [NUM_CLIENTS];

  // Unpack the flat client buses so the winner can be selected by index
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign adr_a[g]   = adr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    assign sel_a[g]   = sel[g*SW +: SW];
  end

  // Winner selection: sticky priority first, otherwise first requester after rr_ptr
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    if (prio_en && req[IDW'(PRIO_CLIENT)]) begin
      found = 1'b1;
      pick  = IDW'(PRIO_CLIENT);
    end else begin
      for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
        cand = {1'b0, rr_ptr} + CW'(i);
        if (cand >= CW'(NUM_CLIENTS)) cand = cand - CW'(NUM_CLIENTS);
        if (!found && req[cand[IDW-1:0]]) begin
          found = 1'b1;
          pick  = cand[IDW-1:0];
        end
      end
    end
  end

  logic timeout_hit;
  assign timeout_hit = mem_busy && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= IDW'(NUM_CLIENTS - 1);
      tcnt        <= '0;
      we_h        <= 1'b0;
      ack         <= '0;
      err         <= '0;
      rdata       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      adr_to_mem  <= '0;
      data_to_mem <= '0;
      sel_to_mem  <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state       <= S_ISSUE;
            busy        <= 1'b1;
            grant_id    <= pick;
            rr_ptr      <= pick;
            we_h        <= we[pick];
            mem_read    <= ~we[pick];
            mem_write   <= we[pick];
            adr_to_mem  <= adr_a[pick];
            data_to_mem <= we[pick] ? wdata_a[pick] : '0;
            sel_to_mem  <= sel_a[pick];
          end
        end
        S_ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!mem_busy || timeout_hit) begin
            // Completion (or abort) returns to IDLE with the ack in the following cycle
            ack[grant_id] <= 1'b1;
            if (mem_busy) err[grant_id] <= 1'b1;
            else if (!we_h) rdata <= data_from_mem;
            state       <= S_IDLE;
            busy        <= 1'b0;
            grant_id    <= '0;
            tcnt        <= '0;
            adr_to_mem  <= '0;
            data_to_mem <= '0;
            sel_to_mem  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: 4 clients, TIMEOUT=8, a simple busy-countdown memory responder.
module tb_mem_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        prio_en;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [127:0] adr;
  logic [127:0] wdata;
  logic [15:0] sel;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [31:0] rdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic        mem_busy = 1'b0;
  logic [31:0] data_from_mem = '0;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;

  int vectors = 0;
  int miscompares = 0;

  int          busy_len = 2;
  int          bcnt = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_word = 32'hDEAD_BEEF;

  mem_arbiter_rr #(
    .NUM_CLIENTS(4), .ADDR_W(32), .DATA_W(32), .PRIO_CLIENT(0), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .prio_en(prio_en), .req(req), .we(we), .adr(adr),
    .wdata(wdata), .sel(sel), .ack(ack), .err(err), .rdata(rdata),
    .grant_id(grant_id), .busy(busy), .mem_busy(mem_busy),
    .data_from_mem(data_from_mem), .mem_read(mem_read), .mem_write(mem_write),
    .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem)
  );

  always #5 clk = ~clk;

  // Memory: busy for busy_len half-cycle-aligned cycles after each strobe; read word derived from address
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      bcnt = busy_len;
      data_from_mem = use_fixed ? fixed_word : {16'hDA7A, adr_to_mem[15:0]};
    end else if (bcnt > 0) begin
      bcnt--;
    end
    mem_busy = (bcnt > 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; prio_en = 1'b0; req = '0; we = '0; sel = '1;
    for (int i = 0; i < 4; i++) begin
      adr[i*32 +: 32]   = 32'(i) * 32'h1000;
      wdata[i*32 +: 32] = 32'hA0A0_0000 | 32'(i);
    end
    cyc(2);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobe", 32'({mem_read, mem_write}), 32'h0);
    chk("rst_adr", adr_to_mem, 32'h0);
    rst = 1'b0;
    cyc(1);

    // Round-robin across all four readers, minimum-latency memory
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("rr_issue_rd", 32'(mem_read), 32'h1);
      chk("rr_grant", 32'(grant_id), 32'(k % 4));
      chk("rr_adr", adr_to_mem, 32'(k % 4) * 32'h1000);
      cyc(1);
      chk("rr_strobe_drop", 32'(mem_read), 32'h0);
      cyc(2);
      chk("rr_ack", 32'(ack), 32'h1 << (k % 4));
      chk("rr_err", 32'(err), 32'h0);
      chk("rr_rdata", rdata, 32'hDA7A_0000 + 32'(k % 4) * 32'h1000);
      chk("rr_ack_grant", 32'(grant_id), 32'h0);
      if (k == 4) req = '0;
    end

    // Client 1 read returning a fixed word
    adr[32 +: 32] = 32'h100;
    use_fixed = 1'b1;
    req = 4'b0010;
    cyc(1);
    chk("rd_read", 32'(mem_read), 32'h1);
    chk("rd_write", 32'(mem_write), 32'h0);
    chk("rd_grant", 32'(grant_id), 32'h1);
    chk("rd_adr", adr_to_mem, 32'h100);
    chk("rd_data_zero", data_to_mem, 32'h0);
    cyc(1);
    chk("rd_one_cycle", 32'(mem_read), 32'h0);
    cyc(2);
    chk("rd_ack", 32'(ack), 32'h2);
    chk("rd_err", 32'(err), 32'h0);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    req = '0;
    use_fixed = 1'b0;

    // Client 3 partial write
    we = 4'b1000;
    wdata[96 +: 32] = 32'h1234_5678;
    sel[12 +: 4] = 4'b0011;
    req = 4'b1000;
    cyc(1);
    chk("wr_write", 32'(mem_write), 32'h1);
    chk("wr_read", 32'(mem_read), 32'h0);
    chk("wr_data", data_to_mem, 32'h1234_5678);
    chk("wr_sel", 32'(sel_to_mem), 32'h3);
    chk("wr_grant", 32'(grant_id), 32'h3);
    cyc(1);
    chk("wr_strobe_drop", 32'(mem_write), 32'h0);
    chk("wr_data_held", data_to_mem, 32'h1234_5678);
    cyc(2);
    chk("wr_ack", 32'(ack), 32'h8);
    chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    req = '0;
    we = '0;
    cyc(1);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_adr", adr_to_mem, 32'h0);
    chk("idle_data", data_to_mem, 32'h0);
    chk("idle_ack", 32'(ack), 32'h0);

    // Sticky priority to client 0, then release
    prio_en = 1'b1;
    req = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("prio_grant", 32'(grant_id), 32'h0);
      cyc(3);
      chk("prio_ack", 32'(ack), 32'h1);
    end
    prio_en = 1'b0;
    cyc(1);
    chk("prio_off_grant", 32'(grant_id), 32'h1);
    chk("prio_off_adr", adr_to_mem, 32'h100);
    req = '0;
    cyc(3);
    chk("dropped_req_ack", 32'(ack), 32'h2);
    chk("dropped_req_rdata", rdata, 32'hDA7A_0100);

    // Hung memory on a client 2 read: abort after 8 WAIT cycles, then serve client 3
    busy_len = 100;
    req = 4'b1100;
    cyc(1);
    chk("to_grant", 32'(grant_id), 32'h2);
    chk("to_adr", adr_to_mem, 32'h2000);
    cyc(9);
    chk("to_no_early_ack", 32'(ack), 32'h0);
    chk("to_still_busy", 32'(busy), 32'h1);
    cyc(1);
    chk("to_ack", 32'(ack), 32'h4);
    chk("to_err", 32'(err), 32'h4);
    chk("to_rdata_kept", rdata, 32'hDA7A_0100);
    chk("to_idle_grant", 32'(grant_id), 32'h0);
    req = 4'b1000;
    busy_len = 2;
    cyc(1);
    chk("to_next_grant", 32'(grant_id), 32'h3);
    chk("to_next_read", 32'(mem_read), 32'h1);
    cyc(3);
    chk("to_next_ack", 32'(ack), 32'h8);
    chk("to_next_err", 32'(err), 32'h0);
    req = '0;

    // Reset in the middle of a hung WAIT
    busy_len = 100;
    req = 4'b0010;
    cyc(1);
    chk("mid_grant", 32'(grant_id), 32'h1);
    cyc(3);
    chk("mid_waiting", 32'(busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_strobe", 32'({mem_read, mem_write}), 32'h0);
    chk("mid_rst_grant", 32'(grant_id), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_adr", adr_to_mem, 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    req = '0;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_no_ack", 32'(ack), 32'h0);
    busy_len = 2;
    req = 4'b0011;
    cyc(1);
    chk("post_rst_grant", 32'(grant_id), 32'h0);
    chk("post_rst_read", 32'(mem_read), 32'h1);
    req = '0;
    cyc(3);
    chk("post_rst_ack", 32'(ack), 32'h1);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
